// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link receiver: FSM states and the link word width.
package sipo_pkg;
  localparam int LINK_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/sipo_out_reg.sv
// Single-entry valid/ready holding register; flags a completed word that had nowhere to go.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             drop
);

  // A pop in the same cycle frees the slot, so only a stalled consumer loses the word.
  assign drop = push && valid && !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (push && (!valid || ready)) begin
      data  <= word;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: frames serial bits into WIDTH-bit words and
// hands them to a valid/ready consumer, with sticky overrun and framing-error flags.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("sipo_deserializer: WIDTH must be at least 2");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] shifted, seeded;
  logic             complete, frame_evt, drop;

  // seeded places a frame's first bit so that WIDTH-1 further shifts land it at its final slot
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg[WIDTH-2:0], serial_in};
      assign seeded  = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin : g_lsb
      assign shifted = {serial_in, shreg[WIDTH-1:1]};
      assign seeded  = {serial_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    shreg_nxt = shreg;
    complete  = 1'b0;
    frame_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bit_valid && frame_start) begin
          shreg_nxt = seeded;
          count_nxt = CW'(1);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_valid && frame_start) begin
          frame_evt = 1'b1;
          shreg_nxt = seeded;
          count_nxt = CW'(1);
        end else if (bit_valid) begin
          shreg_nxt = shifted;
          if (count == CW'(WIDTH - 1)) begin
            complete  = 1'b1;
            count_nxt = '0;
            state_nxt = ST_IDLE;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .push  (complete),
    .word  (shreg_nxt),
    .ready (out_ready),
    .data  (parallel_out),
    .valid (out_valid),
    .drop  (drop)
  );

  // Setting beats clearing so an error coinciding with clr_err is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)           overrun <= 1'b1;
      else if (clr_err)   overrun <= 1'b0;
      if (frame_evt)      frame_err <= 1'b1;
      else if (clr_err)   frame_err <= 1'b0;
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. It is the far end of the team's 4-bit parallel-to-serial shifter link.
- It collects framed serial bits into a WIDTH-bit word and presents the word on a valid/ready output port.
- It detects lost words (overrun) and truncated frames (framing error).
- It sits between the serial link pins/sync stage and the parallel consumer logic.

Parameters:
- WIDTH, 4, bits per word (>=2).
- MSB_FIRST, 1, 1: first received bit lands in parallel_out[WIDTH-1]; 0: first bit lands in parallel_out[0].

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- serial_in  in  1  serial data bit, sampled only when bit_valid=1.
- bit_valid  in  1  bit strobe; one data bit per cycle in which it is high.
- frame_start  in  1  qualifies the current bit_valid bit as bit 0 of a new word; ignored when bit_valid=0.
- parallel_out  out  WIDTH  received word; stable while out_valid=1.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word when out_valid&&out_ready.
- busy  out  1  partial word in progress (state SHIFT).
- overrun  out  1  sticky; a completed word was dropped.
- frame_err  out  1  sticky; a frame_start arrived before the previous word completed.
- clr_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset values: parallel_out=0, out_valid=0, busy=0, overrun=0, frame_err=0. Internally, state=IDLE, bit count=0, shift register=0.
- FSM with two states, IDLE and SHIFT.
- IDLE:
  - bit_valid&&frame_start: capture the bit as bit 0, count=1, go to SHIFT.
  - bit_valid without frame_start: ignore the bit.
  - Exception for WIDTH=1 is not supported; WIDTH>=2 is enforced.
- SHIFT, on bit_valid&&!frame_start: shift the bit in and increment count.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shreg <= {serial_in, shreg[WIDTH-1:1]}.
- Word completion happens when the bit that makes count==WIDTH is sampled:
  - The full word (including that bit) is offered to the output register in the same edge.
  - count returns to 0 and the FSM goes to IDLE.
- Latency: parallel_out/out_valid update at the same clock edge that samples the last bit, so they are visible the cycle after the last bit is presented.
- bit_valid=0 in SHIFT: hold all state. There is no timeout, and gaps of any length are allowed.
- frame_start&&bit_valid in SHIFT (mid-word):
  - Set frame_err and discard the partial word.
  - Restart with this bit as bit 0 (count=1) and stay in SHIFT.
- Output register:
  - Load on completion if out_valid==0, or if out_valid&&out_ready in that same cycle (simultaneous pop and push: new word loaded, out_valid stays 1).
  - On completion with out_valid&&!out_ready: drop the new word, keep the old word, set overrun.
  - out_valid&&out_ready without completion: out_valid <= 0. parallel_out holds its last value.
- Sticky flags and clr_err:
  - clr_err=1 clears overrun and frame_err.
  - If a set event coincides with clr_err, set wins.
- busy = (state==SHIFT).
- Reset mid-operation: asynchronously returns everything to reset values. The partial word and any pending output word are lost, and no flags are set.
- Count width is $clog2(WIDTH+1).

Decomposition:
- Shared package sipo_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT), and
  - the default WIDTH constant LINK_WIDTH=4, shared with the transmitter.
- One natural sub-module: sipo_out_reg, the single-entry valid/ready holding register with overrun detect. The FSM, counter and shifter stay in the top.

Test Plan (all with WIDTH=4 unless noted):
- Basic, MSB_FIRST=1: frame_start on the first bit, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> parallel_out=4'b1011, out_valid=1 for exactly one cycle after the 4th bit; busy high for cycles 2-4.
- LSB-first with gaps: MSB_FIRST=0, bits 1,0,1,1 with bit_valid low for 3 cycles between bits -> parallel_out=4'b1101; no flags set.
- Overrun: out_ready=0, send word 4'hA then 4'h5 -> parallel_out stays 4'hA, overrun=1. Then out_ready=1 for one cycle -> out_valid=0. Then clr_err -> overrun=0.
- Simultaneous pop and push: word 4'h3 pending; the last bit of 4'hC arrives in the same cycle out_ready=1 -> next cycle parallel_out=4'hC, out_valid=1, overrun=0.
- Framing error: 2 bits of one word, then frame_start with bits 0,1,1,0 -> frame_err=1, parallel_out=4'b0110, out_valid=1.
- Reset mid-word and noise: after 3 bits, assert rst asynchronously between edges -> all outputs 0 immediately. Bits without frame_start in IDLE are ignored: busy=0, out_valid=0.
